lcd_serial_responder: RTL and testbench

Serial-side model of the LCD panel's register interface: the responder end of the SPI-like link driven by `lcd_tcvr`. It oversamples the serial clock, enable and data lines in the system clock domain, decodes 16-bit read/write frames, and holds a 128 × 8 register file. For reads it shifts the addressed byte back on the return line. It serves as the panel stand-in for board bring-up and bench loop-back of the `lcd_tcvr` initiator.

---
 rtl/lcd_serial_pkg.sv | 25 ++
 rtl/sync_edge_detect.sv | 43 ++++
 rtl/lcd_serial_responder.sv | 203 ++++++++++++++++++++
 tb/tb_lcd_serial_responder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_serial_pkg.sv
// lcd_serial_pkg
//   Shared definitions for the LCD serial link. Both ends of the link import
//   this package: the lcd_tcvr initiator and the lcd_serial_responder panel
//   model. It holds the frame field widths, the default hardware-config
//   register address and the responder state enumeration.
package lcd_serial_pkg;

    localparam int ADDR_WIDTH  = 7;
    localparam int DATA_WIDTH  = 8;
    localparam int FRAME_WIDTH = 16;
    localparam int CMD_BITS    = FRAME_WIDTH - DATA_WIDTH;   // R/nW + address
    localparam int COUNT_WIDTH = $clog2(FRAME_WIDTH);
    localparam int MEM_DEPTH   = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] HW_CONFIG_ADDRESS = 7'h78;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RD,
        ST_WR,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
//   Brings one asynchronous pin into the i_clock domain through a STAGES-deep
//   flop chain and derives single-cycle rise/fall strobes from the last two
//   flops of the chain.
//
// Ports:
//   i_clock   in   system clock
//   i_nreset  in   asynchronous active-low reset (chain clears to 0)
//   i_async   in   asynchronous pin
//   o_level   out  synchronised level
//   o_rise    out  one-cycle strobe on a synchronised 0->1 transition
//   o_fall    out  one-cycle strobe on a synchronised 1->0 transition
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic i_clock,
    input  logic i_nreset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // One flop beyond the synchroniser depth keeps the previous level, so
    // an edge strobe appears STAGES cycles after the pin and is acted on the
    // cycle after that.
    logic [STAGES:0] r_chain;

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_chain <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop
            // in the chain samples its neighbour's value from before the edge.
            r_chain <= {r_chain[STAGES-1:0], i_async};
        end
    end

    assign o_level = r_chain[STAGES-1];
    assign o_rise  =  r_chain[STAGES-1] & ~r_chain[STAGES];
    assign o_fall  = ~r_chain[STAGES-1] &  r_chain[STAGES];

endmodule

// File: rtl/lcd_serial_responder.sv
// lcd_serial_responder
//   Panel-side responder of the LCD serial register link. Oversamples the
//   serial clock, enable and data pins, decodes 16-bit MSB-first frames
//   (bit 15 R/nW, bits 14:8 address, bits 7:0 data) and holds a 128 x 8
//   register file. Reads shift the addressed byte back on o_txSerial; the
//   hardware-config address always reads HW_CONFIG_VALUE and ignores writes.
//
// Ports:
//   i_clock, i_nreset     system clock, asynchronous active-low reset
//   i_serialClock         serial clock from initiator (idles low)
//   i_serialEnable        frame enable from initiator (active high)
//   i_rxSerial            initiator-to-responder data
//   o_txSerial            responder-to-initiator data (0 unless o_txEnable)
//   o_txEnable            read data is being driven (pad tristate control)
//   o_busy                a frame is in progress
//   o_wrStrobe            one-cycle pulse when a write commits
//   o_wrAddress/o_wrData  address/data of the last committed write
//   o_frameError          one-cycle pulse when a frame is cut short
module lcd_serial_responder #(
    parameter int SYNC_STAGES = 2,
    parameter logic [lcd_serial_pkg::ADDR_WIDTH-1:0] HW_CONFIG_ADDRESS = lcd_serial_pkg::HW_CONFIG_ADDRESS,
    parameter logic [lcd_serial_pkg::DATA_WIDTH-1:0] HW_CONFIG_VALUE   = 8'h20
) (
    input  logic                                  i_clock,
    input  logic                                  i_nreset,
    input  logic                                  i_serialClock,
    input  logic                                  i_serialEnable,
    input  logic                                  i_rxSerial,
    output logic                                  o_txSerial,
    output logic                                  o_txEnable,
    output logic                                  o_busy,
    output logic                                  o_wrStrobe,
    output logic [lcd_serial_pkg::ADDR_WIDTH-1:0] o_wrAddress,
    output logic [lcd_serial_pkg::DATA_WIDTH-1:0] o_wrData,
    output logic                                  o_frameError
);

    import lcd_serial_pkg::*;

    localparam logic [COUNT_WIDTH-1:0] CMD_LAST   = COUNT_WIDTH'(CMD_BITS - 1);
    localparam logic [COUNT_WIDTH-1:0] FRAME_LAST = COUNT_WIDTH'(FRAME_WIDTH - 1);

    // ---------------------------------------------------------------- inputs
    logic w_sclkLevel, w_sclkRise, w_sclkFall;
    logic w_enLevel,   w_enRise,   w_enFall;
    logic w_rxLevel,   w_rxRise,   w_rxFall;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .i_clock(i_clock), .i_nreset(i_nreset), .i_async(i_serialClock),
        .o_level(w_sclkLevel), .o_rise(w_sclkRise), .o_fall(w_sclkFall));

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_en (
        .i_clock(i_clock), .i_nreset(i_nreset), .i_async(i_serialEnable),
        .o_level(w_enLevel), .o_rise(w_enRise), .o_fall(w_enFall));

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_rx (
        .i_clock(i_clock), .i_nreset(i_nreset), .i_async(i_rxSerial),
        .o_level(w_rxLevel), .o_rise(w_rxRise), .o_fall(w_rxFall));

    // Only edges of the clock/enable and the level of the data are needed.
    logic w_unused;
    assign w_unused = ^{w_sclkLevel, w_enLevel, w_rxRise, w_rxFall};

    // ------------------------------------------------------------- registers
    state_t                  r_state, w_nextState;
    logic [COUNT_WIDTH-1:0]  r_bitCount;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_txByte;
    logic                    r_txSerial, r_txEnable;
    logic                    r_wrStrobe, r_frameError;
    logic [ADDR_WIDTH-1:0]   r_wrAddress;
    logic [DATA_WIDTH-1:0]   r_wrData;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    // Shift register contents including the bit being sampled this cycle:
    // the command byte at the 8th rise, the write data at the 16th.
    logic [DATA_WIDTH-1:0]   w_shiftNext;
    logic [DATA_WIDTH-1:0]   w_readValue;
    assign w_shiftNext = {r_shift[DATA_WIDTH-2:0], w_rxLevel};
    assign w_readValue = (w_shiftNext[ADDR_WIDTH-1:0] == HW_CONFIG_ADDRESS)
                       ? HW_CONFIG_VALUE : r_mem[w_shiftNext[ADDR_WIDTH-1:0]];

    // ------------------------------------------------------------------- FSM
    logic w_start, w_shiftIn, w_shiftOut, w_cmdDone, w_commit, w_abort;

    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) r_state <= ST_IDLE;
        else           r_state <= w_nextState;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        w_nextState = r_state;
        w_start     = 1'b0;
        w_shiftIn   = 1'b0;
        w_shiftOut  = 1'b0;
        w_cmdDone   = 1'b0;
        w_commit    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_enRise) begin
                    w_start     = 1'b1;
                    w_nextState = ST_CMD;
                end
            end
            // In the active states an enable fall outranks a serial edge
            // seen in the same cycle: the frame is short, so it is aborted.
            ST_CMD, ST_RD, ST_WR: begin
                if (w_enFall) begin
                    w_abort     = 1'b1;
                    w_nextState = ST_IDLE;
                end else begin
                    w_shiftOut = w_sclkFall && (r_state == ST_RD);
                    if (w_sclkRise) begin
                        w_shiftIn = 1'b1;
                        if (r_state == ST_CMD && r_bitCount == CMD_LAST) begin
                            w_cmdDone   = 1'b1;
                            w_nextState = w_shiftNext[DATA_WIDTH-1] ? ST_RD : ST_WR;
                        end else if (r_state != ST_CMD && r_bitCount == FRAME_LAST) begin
                            w_commit    = (r_state == ST_WR);
                            w_nextState = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (w_enFall) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            r_bitCount   <= '0;
            r_shift      <= '0;
            r_addr       <= '0;
            r_txByte     <= '0;
            r_txSerial   <= 1'b0;
            r_txEnable   <= 1'b0;
            r_wrStrobe   <= 1'b0;
            r_frameError <= 1'b0;
            r_wrAddress  <= '0;
            r_wrData     <= '0;
        end else begin
            r_wrStrobe   <= w_commit;
            r_frameError <= w_abort;

            if (w_start)        r_bitCount <= '0;
            else if (w_shiftIn) r_bitCount <= r_bitCount + 1'b1;

            if (w_shiftIn) r_shift <= w_shiftNext;

            if (w_cmdDone) begin
                r_addr     <= w_shiftNext[ADDR_WIDTH-1:0];
                r_txByte   <= w_readValue;
                r_txEnable <= w_shiftNext[DATA_WIDTH-1];
            end

            // Read byte goes out MSB first, one bit per serial falling edge.
            if (w_shiftOut) begin
                r_txSerial <= r_txByte[DATA_WIDTH-1];
                r_txByte   <= {r_txByte[DATA_WIDTH-2:0], 1'b0};
            end

            if (w_commit) begin
                r_wrAddress <= r_addr;
                r_wrData    <= w_shiftNext;
            end

            if (w_nextState == ST_IDLE) begin
                r_txEnable <= 1'b0;
                r_txSerial <= 1'b0;
            end
        end
    end

    // Register file; the hardware-config address is not backed by storage
    // writes, they are dropped while the strobe still reports them.
    always_ff @(posedge i_clock or negedge i_nreset) begin
        if (!i_nreset) begin
            // NOTE: the register file must read back zero after reset, so it
            // is built from resettable flops rather than an inferred RAM.
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_commit && (r_addr != HW_CONFIG_ADDRESS)) begin
            r_mem[r_addr] <= w_shiftNext;
        end
    end

    // --------------------------------------------------------------- outputs
    assign o_txSerial   = r_txSerial;
    assign o_txEnable   = r_txEnable;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_wrStrobe   = r_wrStrobe;
    assign o_wrAddress  = r_wrAddress;
    assign o_wrData     = r_wrData;
    assign o_frameError = r_frameError;

endmodule

// File: tb/tb_lcd_serial_responder.sv
// tb_lcd_serial_responder
//   Drives the responder as the lcd_tcvr initiator would (data changes on the
//   serial falling edge, sampled on the rising edge) and compares reads,
//   write strobes and frame errors against a register-file model.
module tb_lcd_serial_responder;

    logic       clk    = 1'b0;
    logic       nreset = 1'b0;
    logic       sclk   = 1'b0;
    logic       sen    = 1'b0;
    logic       rx     = 1'b0;
    logic       tx, txen, busy, wrs, ferr;
    logic [6:0] wra;
    logic [7:0] wrd;

    lcd_serial_responder #(
        .SYNC_STAGES      (2),
        .HW_CONFIG_ADDRESS(7'h78),
        .HW_CONFIG_VALUE  (8'h20)
    ) dut (
        .i_clock       (clk),
        .i_nreset      (nreset),
        .i_serialClock (sclk),
        .i_serialEnable(sen),
        .i_rxSerial    (rx),
        .o_txSerial    (tx),
        .o_txEnable    (txen),
        .o_busy        (busy),
        .o_wrStrobe    (wrs),
        .o_wrAddress   (wra),
        .o_wrData      (wrd),
        .o_frameError  (ferr)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Event counters filled by the monitor, sampled mid-cycle.
    int         strobe_cnt    = 0;
    int         error_cnt     = 0;
    int         tx_violations = 0;
    logic [6:0] last_wr_addr  = '0;
    logic [7:0] last_wr_data  = '0;

    always @(posedge clk) begin
        #2;
        if (wrs) begin
            strobe_cnt++;
            last_wr_addr = wra;
            last_wr_data = wrd;
        end
        if (ferr) error_cnt++;
        if (!txen && tx) tx_violations++;
    end

    // Reference register file.
    logic [7:0] model_mem [128];
    int         hp = 4;          // serial half-period in i_clock cycles
    logic [7:0] rd_bits;         // byte seen on tx at rising edges 9..16
    logic       txen_ok;         // txen was low before and high during data
    int         strobe_snap;     // strobe count just before the 17th clock

    function automatic logic [7:0] exp_read(input logic [6:0] addr);
        return (addr == 7'h78) ? 8'h20 : model_mem[addr];
    endfunction

    task automatic model_write(input logic [6:0] addr, input logic [7:0] data);
        if (addr != 7'h78) model_mem[addr] = data;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise enable and issue nclk serial clocks without closing the frame.
    task automatic clock_bits(input logic [15:0] frame, input int nclk);
        txen_ok     = 1'b1;
        rd_bits     = '0;
        strobe_snap = -1;
        @(negedge clk);
        rx  = frame[15];
        sen = 1'b1;
        wait_cycles(hp);
        for (int k = 0; k < nclk; k++) begin
            if (k == 16) strobe_snap = strobe_cnt;
            if (k >= 8 && k < 16) rd_bits[15-k] = tx;
            if (txen !== (frame[15] && k >= 8)) txen_ok = 1'b0;
            sclk = 1'b1;
            wait_cycles(hp);
            sclk = 1'b0;
            if (k + 1 < 16) rx = frame[14-k];
            else            rx = 1'($urandom_range(0, 1));
            wait_cycles(hp);
        end
    endtask

    task automatic finish_frame();
        sen = 1'b0;
        rx  = 1'b0;
        wait_cycles(8);
    endtask

    task automatic send_frame(input logic [15:0] frame, input int nclk);
        clock_bits(frame, nclk);
        finish_frame();
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        wait_cycles(3);
        n_compared++;
        if ({tx, txen, busy, wrs, wra, wrd, ferr} !== 20'h0) begin
            n_mismatched++;
            $display("FAIL reset_outputs: got %h, expected 0", {tx, txen, busy, wrs, wra, wrd, ferr});
        end
        nreset = 1'b1;
        wait_cycles(4);
        n_compared++;
        if ({tx, txen, busy, wrs, wra, wrd, ferr} !== 20'h0) begin
            n_mismatched++;
            $display("FAIL idle_after_reset: got %h, expected 0", {tx, txen, busy, wrs, wra, wrd, ferr});
        end
        for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
    endtask

    task automatic test_hw_config_read();
        int e0 = error_cnt;
        send_frame({1'b1, 7'h78, 8'h00}, 16);
        n_compared++;
        if (rd_bits !== 8'h20) begin
            n_mismatched++;
            $display("FAIL hwcfg_read: got %h, expected 20", rd_bits);
        end
        n_compared++;
        if (txen_ok !== 1'b1) begin
            n_mismatched++;
            $display("FAIL hwcfg_txen_window: got %b, expected 1", txen_ok);
        end
        n_compared++;
        if ({error_cnt - e0, 30'(0)} != 62'h0 || {txen, busy} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL hwcfg_idle: errors %0d txen %b busy %b, expected 0 0 0", error_cnt - e0, txen, busy);
        end
    endtask

    task automatic test_write_then_read(input string name, input logic [6:0] addr, input logic [7:0] data);
        int s0 = strobe_cnt;
        send_frame({1'b0, addr, data}, 16);
        model_write(addr, data);
        n_compared++;
        if ({strobe_cnt - s0, last_wr_addr, last_wr_data} !== {32'd1, addr, data}) begin
            n_mismatched++;
            $display("FAIL %s_strobe: got n=%0d %h/%h, expected n=1 %h/%h",
                     name, strobe_cnt - s0, last_wr_addr, last_wr_data, addr, data);
        end
        send_frame({1'b1, addr, 8'h00}, 16);
        n_compared++;
        if (rd_bits !== exp_read(addr)) begin
            n_mismatched++;
            $display("FAIL %s_readback: got %h, expected %h", name, rd_bits, exp_read(addr));
        end
    endtask

    task automatic test_abort();
        int s0 = strobe_cnt;
        int e0 = error_cnt;
        send_frame({1'b0, 7'h10, 8'h33}, 10);
        n_compared++;
        if ({strobe_cnt - s0, error_cnt - e0} !== {32'd0, 32'd1}) begin
            n_mismatched++;
            $display("FAIL abort_pulses: got strobes %0d errors %0d, expected 0 1", strobe_cnt - s0, error_cnt - e0);
        end
        send_frame({1'b1, 7'h10, 8'h00}, 16);
        n_compared++;
        if (rd_bits !== exp_read(7'h10)) begin
            n_mismatched++;
            $display("FAIL abort_readback: got %h, expected %h", rd_bits, exp_read(7'h10));
        end
    endtask

    task automatic test_extra_clocks();
        int s0 = strobe_cnt;
        int e0 = error_cnt;
        send_frame({1'b0, 7'h01, 8'hA5}, 20);
        model_write(7'h01, 8'hA5);
        n_compared++;
        if (strobe_snap !== s0 + 1) begin
            n_mismatched++;
            $display("FAIL extra_commit_at_16: got %0d, expected %0d", strobe_snap, s0 + 1);
        end
        n_compared++;
        if ({strobe_cnt - s0, error_cnt - e0, last_wr_data} !== {32'd1, 32'd0, 8'hA5}) begin
            n_mismatched++;
            $display("FAIL extra_ignored: got strobes %0d errors %0d data %h, expected 1 0 a5",
                     strobe_cnt - s0, error_cnt - e0, last_wr_data);
        end
        send_frame({1'b1, 7'h01, 8'h00}, 16);
        n_compared++;
        if (rd_bits !== 8'hA5) begin
            n_mismatched++;
            $display("FAIL extra_readback: got %h, expected a5", rd_bits);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic       rnw  = 1'($urandom_range(0, 1));
            logic [6:0] addr = ($urandom_range(0, 5) == 0) ? 7'h78 : 7'($urandom_range(0, 15));
            logic [7:0] data = 8'($urandom);
            int         sel  = $urandom_range(0, 9);
            int         nclk = (sel == 0) ? $urandom_range(1, 15) : (sel == 1) ? 16 + $urandom_range(1, 4) : 16;
            int         s0   = strobe_cnt;
            int         e0   = error_cnt;
            logic [7:0] exp  = exp_read(addr);
            int         exp_s, exp_e;
            hp = $urandom_range(4, 6);
            send_frame({rnw, addr, data}, nclk);
            exp_e = (nclk < 16) ? 1 : 0;
            exp_s = (nclk >= 16 && !rnw) ? 1 : 0;
            if (exp_s == 1) model_write(addr, data);
            n_compared++;
            if ({strobe_cnt - s0, error_cnt - e0} !== {exp_s, exp_e}) begin
                n_mismatched++;
                $display("FAIL rand%0d_pulses: got strobes %0d errors %0d, expected %0d %0d",
                         n, strobe_cnt - s0, error_cnt - e0, exp_s, exp_e);
            end
            if (nclk >= 16 && rnw) begin
                n_compared++;
                if (rd_bits !== exp || txen_ok !== 1'b1) begin
                    n_mismatched++;
                    $display("FAIL rand%0d_read: got %h txen_ok %b, expected %h 1", n, rd_bits, txen_ok, exp);
                end
            end else if (nclk >= 16) begin
                n_compared++;
                if ({last_wr_addr, last_wr_data} !== {addr, data}) begin
                    n_mismatched++;
                    $display("FAIL rand%0d_write: got %h/%h, expected %h/%h", n, last_wr_addr, last_wr_data, addr, data);
                end
            end
        end
        n_compared++;
        if (tx_violations !== 0) begin
            n_mismatched++;
            $display("FAIL tx_zero_when_disabled: got %0d, expected 0", tx_violations);
        end
    endtask

    task automatic test_reset_mid_read();
        int e0 = error_cnt;
        hp = 4;
        clock_bits({1'b1, 7'h01, 8'h00}, 11);
        @(negedge clk);
        nreset = 1'b0;
        #1;
        n_compared++;
        if ({tx, txen, busy, wrs, wra, wrd, ferr} !== 20'h0) begin
            n_mismatched++;
            $display("FAIL midread_reset_outputs: got %h, expected 0", {tx, txen, busy, wrs, wra, wrd, ferr});
        end
        sen  = 1'b0;
        sclk = 1'b0;
        rx   = 1'b0;
        wait_cycles(3);
        nreset = 1'b1;
        for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
        wait_cycles(4);
        n_compared++;
        if (error_cnt !== e0) begin
            n_mismatched++;
            $display("FAIL midread_no_error: got %0d, expected %0d", error_cnt, e0);
        end
        send_frame({1'b1, 7'h01, 8'h00}, 16);
        n_compared++;
        if (rd_bits !== 8'h00) begin
            n_mismatched++;
            $display("FAIL midread_mem_cleared: got %h, expected 00", rd_bits);
        end
        test_write_then_read("post_reset", 7'h22, 8'h3C);
    endtask

    initial begin
        test_reset();
        test_hw_config_read();
        test_write_then_read("wr05", 7'h05, 8'h5A);
        test_write_then_read("wr78", 7'h78, 8'hFF);
        test_abort();
        test_extra_clocks();
        test_random();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
